// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer controller.
package timer_pkg;

    localparam int unsigned FieldW      = 6;
    localparam int unsigned MaxValDflt  = 59;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StExpired
    } timer_state_t;

    function automatic logic [FieldW-1:0] sat_field(input logic [FieldW-1:0] val,
                                                    input logic [FieldW-1:0] limit);
        return (val > limit) ? limit : val;
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchronizer for the 1 Hz divider output plus a rising-edge detector.
module tick_sync (
    input  logic clk,
    input  logic clr,
    input  logic d_in,
    output logic tick
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// Minutes:seconds countdown controller driven by a 1 Hz divider tick.
// Define TIMER_ALARM_EN to hold alarm high in EXPIRED for ALARM_SECS ticks.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 10,
    parameter int unsigned MAX_VAL    = MaxValDflt
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              div_out,
    output logic              div_clr_n,
    input  logic              load,
    input  logic [FieldW-1:0] load_min,
    input  logic [FieldW-1:0] load_sec,
    input  logic              start,
    input  logic              stop,
    output logic [FieldW-1:0] rem_min,
    output logic [FieldW-1:0] rem_sec,
    output logic              running,
    output logic              done,
    output logic              alarm
);

    localparam logic [FieldW-1:0] MaxField  = FieldW'(MAX_VAL);
    localparam logic [FieldW-1:0] AlarmLast = FieldW'(ALARM_SECS - 1);

    timer_state_t      state_q;
    logic [FieldW-1:0] rem_min_q, rem_sec_q;
    logic              running_q, done_q, div_clr_n_q;
    logic              tick;
    logic              rem_nonzero;

    tick_sync u_tick_sync (
        .clk  (clk),
        .clr  (clr),
        .d_in (div_out),
        .tick (tick)
    );

    assign rem_nonzero = (rem_min_q != '0) || (rem_sec_q != '0);

`ifdef TIMER_ALARM_EN
    logic              alarm_q;
    logic [FieldW-1:0] alarm_cnt_q;
    assign alarm = alarm_q;
`else
    logic [FieldW-1:0] unused_alarm_cfg;
    assign unused_alarm_cfg = AlarmLast;
    assign alarm = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            rem_min_q   <= '0;
            rem_sec_q   <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            div_clr_n_q <= 1'b0;
`ifdef TIMER_ALARM_EN
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StPause: begin
                    if (stop && state_q == StPause) begin
                        state_q   <= StIdle;
                        rem_min_q <= '0;
                        rem_sec_q <= '0;
                    end else if (start && rem_nonzero) begin
                        // Divider stays cleared for the first RUN cycle, then is released
                        state_q     <= StRun;
                        running_q   <= 1'b1;
                        div_clr_n_q <= 1'b0;
                    end else if (load) begin
                        rem_min_q <= sat_field(load_min, MaxField);
                        rem_sec_q <= sat_field(load_sec, MaxField);
                    end
                end
                StRun: begin
                    div_clr_n_q <= 1'b1;
                    if (stop) begin
                        state_q     <= StPause;
                        running_q   <= 1'b0;
                        div_clr_n_q <= 1'b0;
                    end else if (tick) begin
                        if (rem_sec_q != '0) begin
                            rem_sec_q <= rem_sec_q - 6'd1;
                        end else if (rem_min_q != '0) begin
                            rem_sec_q <= MaxField;
                            rem_min_q <= rem_min_q - 6'd1;
                        end
                        if (rem_min_q == '0 && rem_sec_q <= 6'd1) begin
                            state_q   <= StExpired;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
`ifdef TIMER_ALARM_EN
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= '0;
`else
                            div_clr_n_q <= 1'b0;
`endif
                        end
                    end
                end
                StExpired: begin
`ifdef TIMER_ALARM_EN
                    if (stop || (tick && alarm_cnt_q == AlarmLast)) begin
                        state_q     <= StIdle;
                        alarm_q     <= 1'b0;
                        div_clr_n_q <= 1'b0;
                    end else if (tick) begin
                        alarm_cnt_q <= alarm_cnt_q + 6'd1;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rem_min   = rem_min_q;
    assign rem_sec   = rem_sec_q;
    assign running   = running_q;
    assign done      = done_q;
    assign div_clr_n = div_clr_n_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl (default and TIMER_ALARM_EN builds).
module tb_timer_ctrl;

`ifdef TIMER_ALARM_EN
    localparam logic AlarmEn = 1'b1;
`else
    localparam logic AlarmEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr, div_out, load, start, stop;
    logic [5:0] load_min, load_sec;
    logic       div_clr_n, running, done, alarm;
    logic [5:0] rem_min, rem_sec;
    int         n_checks = 0;
    int         n_fail   = 0;

    timer_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .div_out   (div_out),
        .div_clr_n (div_clr_n),
        .load      (load),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .start     (start),
        .stop      (stop),
        .rem_min   (rem_min),
        .rem_sec   (rem_sec),
        .running   (running),
        .done      (done),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [5:0] m, input logic [5:0] s);
        load_min = m;
        load_sec = s;
        load = 1'b1;
        clk_n(1);
        load = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        clk_n(1);
        start = 1'b0;
    endtask

    task automatic do_stop;
        stop = 1'b1;
        clk_n(1);
        stop = 1'b0;
    endtask

    task automatic pulse;
        div_out = 1'b1;
        clk_n(4);
        div_out = 1'b0;
        clk_n(4);
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if ({rem_min, rem_sec} !== 12'd0) begin n_fail++; $display("FAIL reset_rem: got %0d:%0d want 0:0", rem_min, rem_sec); end
        n_checks++; if ({running, done, alarm, div_clr_n} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {running, done, alarm, div_clr_n}); end
        clk_n(2);
        n_checks++; if ({running, div_clr_n} !== 2'b00) begin n_fail++; $display("FAIL reset_held: got %b want 00", {running, div_clr_n}); end
        clr = 1'b1;
        clk_n(1);
    endtask

    task automatic test_load_count;
        do_load(6'd1, 6'd2);
        n_checks++; if ({rem_min, rem_sec} !== {6'd1, 6'd2}) begin n_fail++; $display("FAIL load_rem: got %0d:%0d want 1:2", rem_min, rem_sec); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL load_idle: got running=%b want 0", running); end
        do_start;
        n_checks++; if ({running, div_clr_n} !== 2'b10) begin n_fail++; $display("FAIL start_clr: got run,clr_n=%b want 10", {running, div_clr_n}); end
        clk_n(1);
        n_checks++; if (div_clr_n !== 1'b1) begin n_fail++; $display("FAIL start_release: got div_clr_n=%b want 1", div_clr_n); end
        pulse;
        n_checks++; if ({rem_min, rem_sec} !== {6'd1, 6'd1}) begin n_fail++; $display("FAIL count_1: got %0d:%0d want 1:1", rem_min, rem_sec); end
        pulse;
        n_checks++; if ({rem_min, rem_sec} !== {6'd1, 6'd0}) begin n_fail++; $display("FAIL count_2: got %0d:%0d want 1:0", rem_min, rem_sec); end
        pulse;
        n_checks++; if ({rem_min, rem_sec} !== {6'd0, 6'd59}) begin n_fail++; $display("FAIL count_borrow: got %0d:%0d want 0:59", rem_min, rem_sec); end
        do_stop;
        do_stop;
        n_checks++; if ({rem_min, rem_sec, running} !== 13'd0) begin n_fail++; $display("FAIL count_clear: got %0d:%0d run=%b want 0:0 run=0", rem_min, rem_sec, running); end
    endtask

    task automatic test_expiry;
        do_load(6'd0, 6'd2);
        do_start;
        clk_n(1);
        pulse;
        n_checks++; if ({rem_min, rem_sec, running} !== {6'd0, 6'd1, 1'b1}) begin n_fail++; $display("FAIL exp_pre: got %0d:%0d run=%b want 0:1 run=1", rem_min, rem_sec, running); end
        div_out = 1'b1;
        clk_n(3);
        n_checks++; if ({rem_min, rem_sec} !== 12'd0) begin n_fail++; $display("FAIL exp_rem: got %0d:%0d want 0:0", rem_min, rem_sec); end
        n_checks++; if ({done, running} !== 2'b10) begin n_fail++; $display("FAIL exp_done: got done,run=%b want 10", {done, running}); end
        n_checks++; if ({alarm, div_clr_n} !== {AlarmEn, AlarmEn}) begin n_fail++; $display("FAIL exp_alarm: got alarm,clr_n=%b want %b", {alarm, div_clr_n}, {AlarmEn, AlarmEn}); end
        clk_n(1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL exp_done_pulse: got done=%b want 0", done); end
        div_out = 1'b0;
        clk_n(4);
`ifdef TIMER_ALARM_EN
        for (int i = 1; i <= 10; i++) begin
            pulse;
            n_checks++; if (alarm !== (i < 10)) begin n_fail++; $display("FAIL alarm_tick_%0d: got %b want %b", i, alarm, (i < 10)); end
        end
        n_checks++; if ({div_clr_n, running, done} !== 3'b000) begin n_fail++; $display("FAIL alarm_idle: got %b want 000", {div_clr_n, running, done}); end
`else
        pulse;
        n_checks++; if ({alarm, div_clr_n, running} !== 3'b000) begin n_fail++; $display("FAIL noalarm_idle: got %b want 000", {alarm, div_clr_n, running}); end
`endif
        n_checks++; if ({rem_min, rem_sec} !== 12'd0) begin n_fail++; $display("FAIL exp_final: got %0d:%0d want 0:0", rem_min, rem_sec); end
    endtask

    task automatic test_pause_resume;
        do_load(6'd0, 6'd11);
        do_start;
        clk_n(1);
        pulse;
        n_checks++; if ({rem_min, rem_sec} !== {6'd0, 6'd10}) begin n_fail++; $display("FAIL pr_at10: got %0d:%0d want 0:10", rem_min, rem_sec); end
        do_load(6'd5, 6'd5);
        n_checks++; if ({rem_min, rem_sec, running} !== {6'd0, 6'd10, 1'b1}) begin n_fail++; $display("FAIL pr_load_in_run: got %0d:%0d run=%b want 0:10 run=1", rem_min, rem_sec, running); end
        do_start;
        n_checks++; if ({running, div_clr_n} !== 2'b11) begin n_fail++; $display("FAIL pr_start_in_run: got %b want 11", {running, div_clr_n}); end
        div_out = 1'b1;
        clk_n(2);
        stop = 1'b1;
        clk_n(1);
        stop = 1'b0;
        n_checks++; if ({rem_min, rem_sec} !== {6'd0, 6'd10}) begin n_fail++; $display("FAIL pr_stop_wins: got %0d:%0d want 0:10", rem_min, rem_sec); end
        n_checks++; if ({running, div_clr_n} !== 2'b00) begin n_fail++; $display("FAIL pr_paused: got %b want 00", {running, div_clr_n}); end
        div_out = 1'b0;
        clk_n(4);
        pulse;
        n_checks++; if ({rem_min, rem_sec} !== {6'd0, 6'd10}) begin n_fail++; $display("FAIL pr_tick_discard: got %0d:%0d want 0:10", rem_min, rem_sec); end
        do_start;
        n_checks++; if ({running, div_clr_n, rem_sec} !== {2'b10, 6'd10}) begin n_fail++; $display("FAIL pr_resume: got run,clr_n=%b sec=%0d want 10 10", {running, div_clr_n}, rem_sec); end
        do_stop;
        n_checks++; if ({running, rem_sec} !== {1'b0, 6'd10}) begin n_fail++; $display("FAIL pr_stop1: got run=%b sec=%0d want 0 10", running, rem_sec); end
        do_stop;
        n_checks++; if ({rem_min, rem_sec, running} !== 13'd0) begin n_fail++; $display("FAIL pr_stop2: got %0d:%0d run=%b want 0:0 run=0", rem_min, rem_sec, running); end
    endtask

    task automatic test_saturation;
        do_load(6'd63, 6'd63);
        n_checks++; if ({rem_min, rem_sec} !== {6'd59, 6'd59}) begin n_fail++; $display("FAIL sat_both: got %0d:%0d want 59:59", rem_min, rem_sec); end
        do_load(6'd45, 6'd60);
        n_checks++; if ({rem_min, rem_sec} !== {6'd45, 6'd59}) begin n_fail++; $display("FAIL sat_sec: got %0d:%0d want 45:59", rem_min, rem_sec); end
        do_load(6'd0, 6'd0);
        do_start;
        clk_n(2);
        n_checks++; if ({running, div_clr_n, rem_min, rem_sec} !== 14'd0) begin n_fail++; $display("FAIL sat_zero_start: got run,clr_n=%b %0d:%0d want 00 0:0", {running, div_clr_n}, rem_min, rem_sec); end
    endtask

    task automatic test_latency;
        do_load(6'd0, 6'd5);
        do_start;
        clk_n(1);
        div_out = 1'b1;
        clk_n(2);
        n_checks++; if (rem_sec !== 6'd5) begin n_fail++; $display("FAIL lat_early: got sec=%0d want 5", rem_sec); end
        clk_n(1);
        n_checks++; if (rem_sec !== 6'd4) begin n_fail++; $display("FAIL lat_edge: got sec=%0d want 4", rem_sec); end
        clk_n(16384);
        n_checks++; if ({rem_sec, running} !== {6'd4, 1'b1}) begin n_fail++; $display("FAIL lat_hold: got sec=%0d run=%b want 4 1", rem_sec, running); end
        div_out = 1'b0;
        clk_n(4);
        pulse;
        n_checks++; if (rem_sec !== 6'd3) begin n_fail++; $display("FAIL lat_next: got sec=%0d want 3", rem_sec); end
        do_stop;
        do_stop;
    endtask

    task automatic test_reset_mid_run;
        do_load(6'd0, 6'd30);
        do_start;
        clk_n(1);
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL rst_run: got running=%b want 1", running); end
        #3 clr = 1'b0;
        #1;
        n_checks++; if ({rem_min, rem_sec} !== 12'd0) begin n_fail++; $display("FAIL rst_async_rem: got %0d:%0d want 0:0", rem_min, rem_sec); end
        n_checks++; if ({running, done, alarm, div_clr_n} !== 4'b0000) begin n_fail++; $display("FAIL rst_async_flags: got %b want 0000", {running, done, alarm, div_clr_n}); end
        clk_n(2);
        clr = 1'b1;
        clk_n(1);
        do_start;
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL rst_start_zero: got running=%b want 0", running); end
        do_load(6'd0, 6'd3);
        do_start;
        n_checks++; if ({running, rem_sec} !== {1'b1, 6'd3}) begin n_fail++; $display("FAIL rst_resume: got run=%b sec=%0d want 1 3", running, rem_sec); end
    endtask

    initial begin
        clr      = 1'b0;
        div_out  = 1'b0;
        load     = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        load_min = '0;
        load_sec = '0;
        test_reset;
        test_load_count;
        test_expiry;
        test_pause_resume;
        test_saturation;
        test_latency;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
